// File: rtl/wb_proc_master.sv
// rtl/wb_proc_master.sv - Wishbone classic single-cycle initiator for the processor-side slave port
//
// Purpose:
//   Takes one command at a time from a valid/ready command port, runs exactly
//   one Wishbone classic cycle for it, and returns read data plus error/timeout
//   status on a valid/ready response port.
//   The states are IDLE (accepting), BUS (cyc/stb high) and RESP (holding the response).
//
// Optional feature:
//   WB_MASTER_TIMEOUT_EN - when defined, a BUS cycle with no ack/err is aborted
//   after TIMEOUT_CYCLES cycles. It then reports rsp_err_o=1 and rsp_tmo_o=1.
//   When undefined, BUS waits indefinitely and rsp_tmo_o is tied 0.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles in BUS before abort (2..65535, timeout build only)
//   TMO_W           timeout counter width, 2**TMO_W > TIMEOUT_CYCLES
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_adr_i[9:0],     command: direction, word address [11:2],
//   cmd_sel_i[3:0], cmd_dat_i     byte select, write data
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_dat_o, rsp_err_o,         read data (0 unless acked read), error flag,
//   rsp_tmo_o                     timeout flag
//   wb_adr_o, wb_sel_o, wb_we_o,  Wishbone initiator outputs
//   wb_cyc_o, wb_stb_o, wb_dat_o
//   wb_dat_i, wb_ack_i, wb_err_i  Wishbone slave returns
module wb_proc_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMO_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [9:0]  cmd_adr_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_tmo_o,
  output logic [9:0]  wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Reject illegal parameter sets at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || (TIMEOUT_CYCLES >> TMO_W) != 0) begin : g_bad_params
    $error("wb_proc_master: TIMEOUT_CYCLES/TMO_W out of range");
  end

  logic [1:0] state;
  logic       cmd_fire;
  logic       bus_done;
  logic       tmo_hit;

  // cmd_ready_o is only ever high in IDLE. The state term keeps the accept
  // condition explicit.
  assign cmd_fire = (state == ST_IDLE) && cmd_ready_o && cmd_valid_i;
  assign bus_done = wb_ack_i || wb_err_i;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             rsp_tmo_q;

  // The counter reaches TIMEOUT_CYCLES-1 on the edge before the abort edge.
  // This gives exactly TIMEOUT_CYCLES cycles of cyc high.
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_tmo_o = rsp_tmo_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt   <= '0;
      rsp_tmo_q <= 1'b0;
    end else if (cmd_fire) begin
      tmo_cnt <= '0;
    end else if (state == ST_BUS) begin
      // A slave response on the final edge still beats the timeout.
      if (bus_done) begin
        rsp_tmo_q <= 1'b0;
      end else if (tmo_hit) begin
        rsp_tmo_q <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign rsp_tmo_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            wb_we_o     <= cmd_we_i;
            wb_adr_o    <= cmd_adr_i;
            wb_sel_o    <= cmd_sel_i;
            wb_dat_o    <= cmd_dat_i;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            cmd_ready_o <= 1'b0;
            state       <= ST_BUS;
          end else begin
            // cmd_ready_o comes up on the first edge after reset release.
            cmd_ready_o <= 1'b1;
          end
        end

        ST_BUS: begin
          if (bus_done) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= wb_err_i;
            // Data is returned only for a clean acked read. Err overrides ack.
            rsp_dat_o   <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : 32'd0;
            state       <= ST_RESP;
          end else if (tmo_hit) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_dat_o   <= 32'd0;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: begin
          wb_cyc_o    <= 1'b0;
          wb_stb_o    <= 1'b0;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_proc_master.sv
// tb/tb_wb_proc_master.sv - self-checking bench for wb_proc_master
module tb_wb_proc_master;

  localparam int TMO_CYC = 8;
  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_BOTH  = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [9:0]  cmd_adr_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] cmd_dat_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_tmo_o;
  logic [9:0]  wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_proc_master #(.TIMEOUT_CYCLES(TMO_CYC), .TMO_W(16)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_sel_i  (cmd_sel_i),
    .cmd_dat_i  (cmd_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .rsp_tmo_o  (rsp_tmo_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Command currently on the bus, as the bench issued it.
  logic        cur_we;
  logic [9:0]  cur_adr;
  logic [3:0]  cur_sel;
  logic [31:0] cur_dat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference rule for response data: only a read that ends with ack and no err returns data.
  function automatic logic [31:0] exp_rsp_dat(input int kind, input logic we, input logic [31:0] rdata);
    return (kind == K_ACK && !we) ? rdata : 32'd0;
  endfunction

  // Called at a negedge. Presents the command, waits for acceptance, and checks the bus start.
  task automatic issue_cmd(input logic we, input logic [9:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    int n;
    n = 0;
    cur_we = we; cur_adr = adr; cur_sel = sel; cur_dat = dat;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
    while (!cmd_ready_o && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("cmd_accept_bound", 32'(n < 50), 32'd1);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'($urandom); cmd_adr_i = 10'($urandom); cmd_sel_i = 4'($urandom); cmd_dat_i = $urandom;
    check("cyc_start", wb_cyc_o, 1);
    check("stb_start", wb_stb_o, 1);
    check("cmd_ready_busy", cmd_ready_o, 0);
    check("wb_we", wb_we_o, cur_we);
    check("wb_adr", wb_adr_o, cur_adr);
    check("wb_sel", wb_sel_o, cur_sel);
    check("wb_dat_o", wb_dat_o, cur_dat);
  endtask

  // Slave inserts 'waits' wait states, then ends the cycle with ack, err or both.
  task automatic respond(input int kind, input int waits, input logic [31:0] rdata);
    int cyc_n;
    cyc_n = 1;
    for (int i = 0; i < waits; i++) begin
      @(negedge wb_clk_i);
      if (wb_cyc_o && wb_stb_o) cyc_n++;
      check("adr_stable", wb_adr_o, cur_adr);
      check("dat_o_stable", wb_dat_o, cur_dat);
    end
    wb_ack_i = (kind != K_ERR);
    wb_err_i = (kind != K_ACK);
    wb_dat_i = rdata;
    @(negedge wb_clk_i);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
    check("cyc_len", 32'(cyc_n), 32'(waits + 1));
    check("cyc_end", wb_cyc_o, 0);
    check("stb_end", wb_stb_o, 0);
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_dat", rsp_dat_o, exp_rsp_dat(kind, cur_we, rdata));
    check("rsp_err", rsp_err_o, 32'(kind != K_ACK));
    check("rsp_tmo", rsp_tmo_o, 0);
  endtask

  // Holds rsp_ready low for 'delay' cycles with stray slave strobes, then consumes the response.
  task automatic collect(input int delay, input logic [31:0] e_dat, input logic e_err, input logic e_tmo);
    rsp_ready_i = 1'b0;
    for (int i = 0; i < delay; i++) begin
      wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom); wb_dat_i = $urandom;
      @(negedge wb_clk_i);
      check("hold_valid", rsp_valid_o, 1);
      check("hold_dat", rsp_dat_o, e_dat);
      check("hold_err", rsp_err_o, e_err);
      check("hold_tmo", rsp_tmo_o, e_tmo);
      check("hold_cyc", wb_cyc_o, 0);
      check("hold_cmd_ready", cmd_ready_o, 0);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_consumed", rsp_valid_o, 0);
    check("ready_after_rsp", cmd_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_sel_i = '0;
    cmd_dat_i = '0; rsp_ready_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

    @(negedge wb_clk_i);
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_dat", rsp_dat_o, 0);
    check("rst_rsp_err", {rsp_err_o, rsp_tmo_o}, 0);
    check("rst_wb_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check("rst_wb_adr_sel", {wb_adr_o, wb_sel_o}, 0);
    check("rst_wb_dat", wb_dat_o, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("ready_after_rst", cmd_ready_o, 1);

    // Read with two wait states.
    issue_cmd(1'b0, 10'h3FF, 4'hF, 32'h0);
    respond(K_ACK, 2, 32'hDEADBEEF);
    collect(0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Zero-wait write.
    issue_cmd(1'b1, 10'h004, 4'b0011, 32'h12345678);
    respond(K_ACK, 0, 32'hCAFEF00D);
    collect(1, 32'h0, 1'b0, 1'b0);

    // Ack and err together: err wins.
    issue_cmd(1'b0, 10'h155, 4'hF, 32'h0);
    respond(K_BOTH, 1, 32'hFFFFFFFF);
    collect(0, 32'h0, 1'b1, 1'b0);

    // Response back-pressure with a second command waiting at the port.
    issue_cmd(1'b0, 10'h020, 4'h1, 32'h0);
    respond(K_ACK, 0, 32'hA5A5_0001);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 10'h021; cmd_sel_i = 4'h2; cmd_dat_i = 32'h0BAD_F00D;
    collect(5, 32'hA5A5_0001, 1'b0, 1'b0);
    issue_cmd(1'b1, 10'h021, 4'h2, 32'h0BAD_F00D);
    respond(K_ERR, 1, 32'h1111_2222);
    collect(0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a bus cycle.
    issue_cmd(1'b0, 10'h0AA, 4'hC, 32'h0);
    @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    check("arst_cyc", wb_cyc_o, 0);
    check("arst_stb", wb_stb_o, 0);
    check("arst_rsp_valid", rsp_valid_o, 0);
    check("arst_wb_adr", wb_adr_o, 0);
    wb_ack_i = 1'b1;
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    wb_ack_i = 1'b0;
    check("post_rst_no_rsp", rsp_valid_o, 0);
    check("post_rst_cyc", wb_cyc_o, 0);
    check("post_rst_ready", cmd_ready_o, 1);
    issue_cmd(1'b0, 10'h0AB, 4'hF, 32'h0);
    respond(K_ACK, 1, 32'h7654_3210);
    collect(0, 32'h7654_3210, 1'b0, 1'b0);

`ifdef WB_MASTER_TIMEOUT_EN
    begin
      int cyc_n;
      // Silent slave: abort after exactly TMO_CYC cycles of cyc.
      issue_cmd(1'b0, 10'h3C3, 4'hF, 32'h0);
      cyc_n = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge wb_clk_i);
        if (!wb_cyc_o) break;
        cyc_n++;
      end
      check("tmo_cyc_len", 32'(cyc_n), 32'(TMO_CYC));
      check("tmo_rsp_valid", rsp_valid_o, 1);
      check("tmo_rsp_err", rsp_err_o, 1);
      check("tmo_rsp_tmo", rsp_tmo_o, 1);
      check("tmo_rsp_dat", rsp_dat_o, 0);
      collect(2, 32'h0, 1'b1, 1'b1);
      // Ack on the last possible edge beats the timeout.
      issue_cmd(1'b0, 10'h3C4, 4'hF, 32'h0);
      respond(K_ACK, TMO_CYC - 1, 32'h5EED_5EED);
      collect(0, 32'h5EED_5EED, 1'b0, 1'b0);
    end
`endif

    // Randomized traffic checked against the response rules.
    for (int t = 0; t < 24; t++) begin
      logic        we;
      logic [31:0] rdata;
      int          r, kind, waits, delay;
      we    = 1'($urandom);
      rdata = $urandom;
      r     = int'($urandom_range(0, 9));
      kind  = (r < 7) ? K_ACK : (r < 9) ? K_ERR : K_BOTH;
      waits = int'($urandom_range(0, 4));
      delay = int'($urandom_range(0, 3));
      issue_cmd(we, 10'($urandom), 4'($urandom), $urandom);
      respond(kind, waits, rdata);
      collect(delay, exp_rsp_dat(kind, we, rdata), kind != K_ACK, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_proc_master.md
Name: wb_proc_master

Overview:
- Wishbone classic single-cycle initiator that drives the processor-side Wishbone slave port: 10-bit word address, 4-bit byte select, 32-bit data.
- Accepts one command at a time from a local valid/ready command port and runs one Wishbone cycle per command.
- Returns read data and error/timeout status on a valid/ready response port.
- Used as the processor-side stimulus/bridge block in the WB environment.

Parameters:
- TIMEOUT_CYCLES, 256, cycles in BUS with no ack/err before abort (only with WB_MASTER_TIMEOUT_EN); legal range 2..65535.
- TMO_W, 16, width of the timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  sole clock; all logic on posedge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid&ready at posedge.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  10  word address [11:2].
- cmd_sel_i  in  4  byte select.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid&ready at posedge.
- rsp_dat_o  out  32  read data; 0 for writes, errors and timeouts.
- rsp_err_o  out  1  cycle ended by wb_err_i or timeout.
- rsp_tmo_o  out  1  cycle ended by timeout.
- wb_adr_o  out  10  Wishbone address [11:2].
- wb_sel_o  out  4  byte select.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_dat_o  out  32  write data to slave.
- wb_dat_i  in  32  read data from slave.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.

Behaviour:
- Reset: all outputs registered and 0. This covers cmd_ready_o, rsp_*, wb_cyc_o/stb_o/we_o, wb_adr_o, wb_sel_o and wb_dat_o. FSM goes to IDLE.
- Reset is asynchronous. Asserting it mid-cycle drops cyc/stb immediately; the in-flight command is discarded and no response is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On posedge with cmd_valid_i: latch we/adr/sel/dat onto wb_* outputs, assert wb_cyc_o and wb_stb_o, clear the timeout counter, go to BUS, drop cmd_ready_o.
  - Latency: command accepted at edge N gives cyc/stb high from N+1.
- BUS:
  - cyc/stb held high; adr/sel/we/dat held stable.
  - wb_ack_i or wb_err_i sampled high at posedge M: deassert cyc/stb at M, go to RESP, and set rsp_valid_o=1 from M onward (visible the cycle after M-1).
  - rsp_dat_o = wb_dat_i only on ack of a read; otherwise 0.
  - rsp_err_o = wb_err_i.
  - ack and err together: err wins, so rsp_err_o=1 and rsp_dat_o=0.
  - Zero-wait slave (ack in the first BUS cycle) gives cyc/stb high for exactly 1 cycle.
- RESP:
  - rsp_valid_o and rsp_* held stable until rsp_ready_i at a posedge; then clear rsp_valid_o and go to IDLE with cmd_ready_o=1 next cycle.
  - Minimum throughput: 3 cycles per command (IDLE, BUS, RESP with rsp_ready_i tied 1).
- wb_ack_i/wb_err_i outside BUS are ignored and change no state.
- wb_adr_o/sel/we/dat_o keep the last command's values after the cycle ends; slaves must qualify them with cyc&stb.
- cmd_valid_i while cmd_ready_o=0 is held off; the command stays at the port and is not dropped.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - TMO_W-bit counter increments each BUS cycle with no ack/err.
  - When the counter reaches TIMEOUT_CYCLES-1 without response, the next posedge drops cyc/stb and goes to RESP with rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0. Total cyc high is exactly TIMEOUT_CYCLES cycles.
  - ack/err on that same final edge takes priority over timeout, with rsp_tmo_o=0.
- Undefined:
  - No counter; BUS waits indefinitely.
  - rsp_tmo_o tied 0.

Test Plan:
- Read, slave acks after 2 wait cycles with wb_dat_i=32'hDEADBEEF, adr=10'h3FF, sel=4'hF -> cyc/stb high 3 cycles; wb_adr_o=10'h3FF throughout; rsp_valid_o with rsp_dat_o=32'hDEADBEEF, rsp_err_o=0.
- Write adr=10'h004, sel=4'b0011, dat=32'h12345678, zero-wait ack -> wb_we_o=1, wb_dat_o=32'h12345678, cyc high 1 cycle; rsp_dat_o=0, rsp_err_o=0.
- Read with ack and err in the same cycle, wb_dat_i=32'hFFFFFFFF -> rsp_err_o=1, rsp_dat_o=0.
- rsp_ready_i held 0 for 5 cycles with a new cmd_valid_i pending -> rsp_* stable for 5 cycles, cmd_ready_o=0, no second cyc until the response is consumed.
- wb_rst_i pulsed mid-BUS (asynchronous, between edges) -> cyc/stb/rsp_valid_o go 0 immediately; no response; next command after reset is processed normally.
- WB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave silent -> cyc high exactly 8 cycles, then rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0.
